spi_burst_sequencer: RTL and testbench

//  Host-side sequencer that sits directly upstream of the SPI master core.

---
 rtl/spi_burst_sequencer.sv | 150 +++++++++++++++
 tb/tb_spi_burst_sequencer.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_burst_sequencer.sv
// rtl/spi_burst_sequencer.sv - N-byte full-duplex burst sequencer in front of the SPI master core
// Optional WAIT_RX abort: define SPI_SEQ_TIMEOUT_EN (adds TIMEOUT_CYC parameter and timeout logic).
module spi_burst_sequencer #(
  parameter int LEN_W = 8
`ifdef SPI_SEQ_TIMEOUT_EN
  , parameter int TIMEOUT_CYC = 4096
`endif
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic [1:0]       cfg_spibr,
  input  logic [1:0]       cfg_mode,
  input  logic [7:0]       tx_data,
  input  logic             tx_valid,
  output logic             tx_ready,
  output logic [7:0]       rx_data,
  output logic             rx_valid,
  input  logic             rx_ready,
  output logic             busy,
  output logic             done,
  output logic             timeout,
  output logic [1:0]       spi_spibr,
  output logic [2:0]       spi_spicr,
  output logic             spi_wr_settings,
  output logic [7:0]       spi_data_in,
  output logic             spi_write_byte,
  output logic             spi_read_byte,
  input  logic [7:0]       spi_data_out,
  input  logic             spi_ready_to_read
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_CFG     = 3'd1;
  localparam logic [2:0] S_LOAD    = 3'd2;
  localparam logic [2:0] S_WAIT_RX = 3'd3;
  localparam logic [2:0] S_POP     = 3'd4;
  localparam logic [2:0] S_CAP     = 3'd5;
  localparam logic [2:0] S_HOLD    = 3'd6;
  localparam logic [2:0] S_DONE    = 3'd7;

  logic [2:0]       state;
  logic [LEN_W-1:0] remaining;
  logic [1:0]       br_q;
  logic [1:0]       mode_q;
  logic             in_byte;

`ifdef SPI_SEQ_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0] wait_cnt;
  logic             timeout_q;
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      state          <= S_IDLE;
      remaining      <= '0;
      br_q           <= '0;
      mode_q         <= '0;
      spi_data_in    <= '0;
      spi_write_byte <= 1'b0;
      rx_data        <= '0;
      rx_valid       <= 1'b0;
`ifdef SPI_SEQ_TIMEOUT_EN
      wait_cnt       <= '0;
      timeout_q      <= 1'b0;
`endif
    end else begin
      spi_write_byte <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
`ifdef SPI_SEQ_TIMEOUT_EN
            timeout_q <= 1'b0;
`endif
            if (len != '0) begin
              remaining <= len;
              br_q      <= cfg_spibr;
              mode_q    <= cfg_mode;
              state     <= S_CFG;
            end else begin
              state <= S_DONE;
            end
          end
        end
        S_CFG: state <= S_LOAD;
        S_LOAD: begin
          if (tx_valid) begin
            spi_data_in    <= tx_data;
            spi_write_byte <= 1'b1;
            state          <= S_WAIT_RX;
`ifdef SPI_SEQ_TIMEOUT_EN
            wait_cnt       <= '0;
`endif
          end
        end
        S_WAIT_RX: begin
          if (spi_ready_to_read) begin
            state <= S_POP;
          end
`ifdef SPI_SEQ_TIMEOUT_EN
          else if (wait_cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
            // Abandon the rest of the burst; the host still sees a done pulse.
            timeout_q <= 1'b1;
            remaining <= '0;
            state     <= S_DONE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
`endif
        end
        S_POP: state <= S_CAP;
        S_CAP: begin
          rx_data  <= spi_data_out;
          rx_valid <= 1'b1;
          state    <= S_HOLD;
        end
        S_HOLD: begin
          if (rx_ready) begin
            rx_valid  <= 1'b0;
            remaining <= remaining - LEN_W'(1);
            state     <= (remaining == LEN_W'(1)) ? S_DONE : S_LOAD;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // eop covers the whole last-byte exchange, from its LOAD up to (not including) DONE.
  assign in_byte = (state == S_LOAD) || (state == S_WAIT_RX) || (state == S_POP) ||
                   (state == S_CAP)  || (state == S_HOLD);

  assign tx_ready        = (state == S_LOAD);
  assign busy            = (state != S_IDLE);
  assign done            = (state == S_DONE);
  assign spi_wr_settings = (state == S_CFG);
  assign spi_read_byte   = (state == S_POP);
  assign spi_spibr       = br_q;
  assign spi_spicr       = {in_byte && (remaining == LEN_W'(1)), mode_q};

`ifdef SPI_SEQ_TIMEOUT_EN
  assign timeout = timeout_q;
`else
  assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_spi_burst_sequencer.sv
// tb/tb_spi_burst_sequencer.sv - scoreboard bench for spi_burst_sequencer with a loopback SPI core model
module tb_spi_burst_sequencer;
  localparam int LEN_W = 8;
`ifdef SPI_SEQ_TIMEOUT_EN
  localparam int TO = 16;
`endif

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             start = 1'b0;
  logic [LEN_W-1:0] len = '0;
  logic [1:0]       cfg_spibr = '0;
  logic [1:0]       cfg_mode = '0;
  logic [7:0]       tx_data = '0;
  logic             tx_valid = 1'b0;
  logic             tx_ready;
  logic [7:0]       rx_data;
  logic             rx_valid;
  logic             rx_ready = 1'b0;
  logic             busy, done, timeout;
  logic [1:0]       spi_spibr;
  logic [2:0]       spi_spicr;
  logic             spi_wr_settings, spi_write_byte, spi_read_byte;
  logic [7:0]       spi_data_in;
  logic [7:0]       spi_data_out = '0;
  logic             spi_ready_to_read = 1'b0;

  spi_burst_sequencer #(
    .LEN_W(LEN_W)
`ifdef SPI_SEQ_TIMEOUT_EN
    , .TIMEOUT_CYC(TO)
`endif
  ) dut (
    .clk(clk), .reset(reset), .start(start), .len(len), .cfg_spibr(cfg_spibr), .cfg_mode(cfg_mode),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .busy(busy), .done(done), .timeout(timeout),
    .spi_spibr(spi_spibr), .spi_spicr(spi_spicr), .spi_wr_settings(spi_wr_settings),
    .spi_data_in(spi_data_in), .spi_write_byte(spi_write_byte), .spi_read_byte(spi_read_byte),
    .spi_data_out(spi_data_out), .spi_ready_to_read(spi_ready_to_read)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  logic [7:0] exp_rx_q[$];
  logic [7:0] exp_tx_q[$];
  bit         exp_eop_q[$];
  logic [7:0] dir_tx[$];
  logic [1:0] exp_br = '0, exp_mode = '0;
  int n_wr, n_rd, n_set, n_done;
  int stall_req = 0;
  int core_delay_force = -1;
  bit core_mute = 0;

  function automatic void chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Host RX side: random backpressure, or a forced stall counted in rx_valid cycles.
  initial forever begin
    step();
    if (stall_req > 0) begin
      rx_ready = 1'b0;
      if (rx_valid) stall_req--;
    end else begin
      rx_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // SPI core model: loops each written byte back after a random latency.
  initial begin
    logic [7:0] core_byte;
    bit core_pend, dout_fresh;
    int core_cd;
    core_byte = '0; core_pend = 0; dout_fresh = 0; core_cd = 0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        core_pend = 0;
        spi_ready_to_read = 1'b0;
      end else begin
        if (spi_read_byte) begin
          spi_data_out = core_byte;
          spi_ready_to_read = 1'b0;
          core_pend = 0;
          dout_fresh = 1;
        end else if (dout_fresh) begin
          dout_fresh = 0;
        end else begin
          spi_data_out = 8'($urandom);
        end
        if (spi_write_byte) begin
          core_byte = spi_data_in;
          core_pend = 1;
          core_cd = (core_delay_force >= 0) ? core_delay_force : $urandom_range(0, 4);
        end else if (core_pend && !core_mute) begin
          if (core_cd == 0) spi_ready_to_read = 1'b1;
          else core_cd--;
        end
      end
    end
  end

  // Monitor: pops the scoreboard whenever the DUT presents a byte to the core or the host.
  initial begin
    bit prev_stalled;
    logic [7:0] prev_rx;
    prev_stalled = 0; prev_rx = '0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        prev_stalled = 0;
      end else begin
        if (spi_write_byte) begin
          n_wr++;
          if (exp_tx_q.size() == 0) chk("unexpected_write", 1, 0);
          else begin
            chk("spi_data_in", spi_data_in, exp_tx_q.pop_front());
            chk("eop_on_write", spi_spicr[2], exp_eop_q.pop_front());
          end
        end
        if (spi_read_byte) n_rd++;
        if (spi_wr_settings) begin
          n_set++;
          chk("spibr", spi_spibr, exp_br);
          chk("mode", spi_spicr[1:0], exp_mode);
        end
        if (done) n_done++;
        if (prev_stalled) begin
          chk("rx_valid_hold", rx_valid, 1);
          chk("rx_data_stable", rx_data, prev_rx);
        end
        if (rx_valid) begin
          chk("no_tx_ready_in_hold", tx_ready, 0);
          if (rx_ready) begin
            if (exp_rx_q.size() == 0) chk("unexpected_rx", 1, 0);
            else chk("rx_data", rx_data, exp_rx_q.pop_front());
          end
        end
        prev_stalled = rx_valid && !rx_ready;
        prev_rx = rx_data;
      end
    end
  end

  task automatic clear_counts();
    n_wr = 0; n_rd = 0; n_set = 0; n_done = 0;
  endtask

  task automatic run_burst(input int n, input int abort_byte, input logic [1:0] br,
                           input logic [1:0] mode, input bit pulse_busy);
    int guard;
    logic [7:0] b;
    clear_counts();
    exp_br = br; exp_mode = mode;
    start = 1'b1; len = LEN_W'(n); cfg_spibr = br; cfg_mode = mode;
    step();
    start = 1'b0; len = LEN_W'($urandom); cfg_spibr = 2'($urandom); cfg_mode = 2'($urandom);
    chk("busy_after_start", busy, 1);
    chk("timeout_clear_on_start", timeout, 0);
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, 2)) step();
      if (i > 0 && (pulse_busy || $urandom_range(0, 3) == 0)) begin
        start = 1'b1; len = LEN_W'($urandom_range(1, 9));
        step();
        start = 1'b0;
      end
      b = (dir_tx.size() > 0) ? dir_tx.pop_front() : 8'($urandom);
      tx_data = b; tx_valid = 1'b1;
      guard = 0;
      while (!tx_ready && guard < 300) begin step(); guard++; end
      if (guard >= 300) begin
        chk("tx_ready_wait_expired", 0, 1);
        tx_valid = 1'b0;
        return;
      end
      exp_tx_q.push_back(b); exp_rx_q.push_back(b); exp_eop_q.push_back(i == n - 1);
      step();
      tx_valid = 1'b0; tx_data = 8'($urandom);
      if (i == abort_byte) return;
    end
    guard = 0;
    while (busy && guard < 500) begin step(); guard++; end
    chk("burst_end_wait", guard < 500, 1);
    chk("write_pulses", n_wr, n);
    chk("read_pulses", n_rd, n);
    chk("wr_settings_pulses", n_set, (n > 0) ? 1 : 0);
    chk("done_pulses", n_done, 1);
    chk("rx_queue_drained", exp_rx_q.size(), 0);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    step();
    chk("reset_outputs", {tx_ready, rx_data, rx_valid, busy, done, timeout, spi_spibr, spi_spicr,
                          spi_wr_settings, spi_data_in, spi_write_byte, spi_read_byte}, 0);
    exp_rx_q.delete(); exp_tx_q.delete(); exp_eop_q.delete();
    reset = 1'b1;
    step();
  endtask

  initial begin
    repeat (2) step();
    do_reset();

    // Directed loopback burst of three bytes.
    dir_tx = '{8'hA5, 8'h3C, 8'hFF};
    run_burst(3, -1, 2'b01, 2'b00, 0);

    // Zero-length start: immediate done, no SPI traffic; next start right after done.
    clear_counts();
    start = 1'b1; len = '0;
    step();
    start = 1'b0;
    chk("len0_done", done, 1);
    step();
    chk("len0_done_width", done, 0);
    chk("len0_idle", busy, 0);
    chk("len0_no_traffic", n_wr + n_rd + n_set, 0);
    run_burst(1, -1, 2'b10, 2'b01, 0);

    // Host stall on byte 1.
    stall_req = 10;
    run_burst(2, -1, 2'b00, 2'b11, 0);
    stall_req = 0;

    // Config latch and ignored starts while busy.
    run_burst(3, -1, 2'b11, 2'b10, 1);
    chk("cfg_spibr_kept", spi_spibr, 3);
    chk("cfg_mode_kept", spi_spicr[1:0], 2'b10);

    // Reset during WAIT_RX of byte 2 of 4, then a fresh single-byte burst.
    core_delay_force = 30;
    run_burst(4, 1, 2'b01, 2'b01, 0);
    repeat (3) step();
    chk("wait_rx_busy", busy, 1);
    core_delay_force = -1;
    do_reset();
    run_burst(1, -1, 2'b10, 2'b00, 0);

    // Core never answers.
    core_mute = 1;
    run_burst(1, 0, 2'b00, 2'b00, 0);
`ifdef SPI_SEQ_TIMEOUT_EN
    repeat (TO - 1) step();
    chk("pre_timeout_done", done, 0);
    chk("pre_timeout_flag", timeout, 0);
    step();
    chk("timeout_done", done, 1);
    chk("timeout_flag", timeout, 1);
    step();
    chk("timeout_sticky", timeout, 1);
    chk("timeout_idle", busy, 0);
    exp_rx_q.delete();
    core_mute = 0;
    run_burst(1, -1, 2'b01, 2'b10, 0);
`else
    repeat (40) step();
    chk("no_timeout_busy", busy, 1);
    chk("no_timeout_flag", timeout, 0);
    core_mute = 0;
    do_reset();
`endif

    // Randomized bursts.
    for (int k = 0; k < 30; k++) begin
      run_burst($urandom_range(1, 8), -1, 2'($urandom), 2'($urandom), 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
